// File: rtl/div_sched_pkg.sv
// Shared types and constants for the div_sched divide sequencer.
package div_sched_pkg;

  localparam int DIV_ITER = 32;
  localparam int RESULT_W = 2 * DIV_ITER;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_ZERO = 2'd1,
    DIV_ON   = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on a {remainder, quotient} shift register.
module div_step #(
  parameter int DIV_W = 32
) (
  input  logic [2*DIV_W:0]  pr_i,
  input  logic [DIV_W-1:0]  divisor_i,
  output logic [2*DIV_W:0]  pr_o
);

  logic [2*DIV_W:0] shifted;
  logic [DIV_W+1:0] diff;
  logic             unused_msb;

  // The partial remainder always stays below the divisor, so the MSB shifted out is zero.
  assign unused_msb = pr_i[2*DIV_W];

  always_comb begin
    shifted = {pr_i[2*DIV_W-1:0], 1'b0};
    diff    = {1'b0, shifted[2*DIV_W:DIV_W]} - {2'b00, divisor_i};
    pr_o    = shifted;
    if (!diff[DIV_W+1]) begin
      pr_o = {diff[DIV_W:0], shifted[DIV_W-1:1], 1'b1};
    end
  end

endmodule

// File: rtl/div_sched.sv
// Multi-cycle DIV/DIVU sequencer for the HI/LO datapath.
// Optional macro DIV_FAST_ZERO_EN: a zero divisor short-cuts through the ZERO state.
module div_sched
  import div_sched_pkg::*;
#(
  parameter int DIV_W = DIV_ITER
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_i,
  input  logic [DIV_W-1:0]   dividend_i,
  input  logic [DIV_W-1:0]   divisor_i,
  input  logic               annul_i,
  output logic               stall_o,
  output logic               busy_o,
  output logic               ready_o,
  output logic [2*DIV_W-1:0] result_o
);

  localparam int CNT_W = $clog2(DIV_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_W - 1);

  div_state_e         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*DIV_W:0]   pr_q;
  logic [DIV_W-1:0]   divisor_q;
  logic               quot_neg_q;
  logic               rem_neg_q;
  logic               zero_q;
  logic [2*DIV_W-1:0] result_q;

  logic [2*DIV_W:0]   step_d;
  logic [DIV_W-1:0]   dvd_mag;
  logic [DIV_W-1:0]   dvs_mag;

  assign dvd_mag = (signed_i && dividend_i[DIV_W-1]) ? (~dividend_i + DIV_W'(1)) : dividend_i;
  assign dvs_mag = (signed_i && divisor_i[DIV_W-1])  ? (~divisor_i + DIV_W'(1))  : divisor_i;

  div_step #(.DIV_W(DIV_W)) u_step (
    .pr_i      (pr_q),
    .divisor_i (divisor_q),
    .pr_o      (step_d)
  );

  // Negating the remainder magnitude of a divide-by-zero restores the raw dividend,
  // so only the quotient needs forcing to all ones.
  function automatic logic [2*DIV_W-1:0] fixup(input logic [2*DIV_W:0] pr,
                                               input logic qn,
                                               input logic rn,
                                               input logic z);
    logic [DIV_W-1:0] q;
    logic [DIV_W-1:0] r;
    q = pr[DIV_W-1:0];
    r = pr[2*DIV_W-1:DIV_W];
    if (qn) q = ~q + DIV_W'(1);
    if (rn) r = ~r + DIV_W'(1);
    if (z)  q = '1;
    return {r, q};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_IDLE;
      cnt_q      <= '0;
      pr_q       <= '0;
      divisor_q  <= '0;
      quot_neg_q <= 1'b0;
      rem_neg_q  <= 1'b0;
      zero_q     <= 1'b0;
      result_q   <= '0;
    end else if (annul_i) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start_i) begin
            pr_q       <= {{(DIV_W+1){1'b0}}, dvd_mag};
            divisor_q  <= dvs_mag;
            quot_neg_q <= signed_i & (dividend_i[DIV_W-1] ^ divisor_i[DIV_W-1]);
            rem_neg_q  <= signed_i & dividend_i[DIV_W-1];
            zero_q     <= (divisor_i == '0);
            cnt_q      <= '0;
`ifdef DIV_FAST_ZERO_EN
            state_q    <= (divisor_i == '0) ? DIV_ZERO : DIV_ON;
`else
            state_q    <= DIV_ON;
`endif
          end
        end
`ifdef DIV_FAST_ZERO_EN
        DIV_ZERO: begin
          result_q <= fixup({1'b0, pr_q[DIV_W-1:0], {DIV_W{1'b1}}}, quot_neg_q, rem_neg_q, 1'b1);
          state_q  <= DIV_DONE;
        end
`endif
        DIV_ON: begin
          pr_q  <= step_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            result_q <= fixup(step_d, quot_neg_q, rem_neg_q, zero_q);
            state_q  <= DIV_DONE;
          end
        end
        DIV_DONE: begin
          state_q <= DIV_IDLE;
        end
        default: begin
          state_q <= DIV_IDLE;
        end
      endcase
    end
  end

  assign busy_o   = (state_q == DIV_ON) || (state_q == DIV_ZERO);
  assign ready_o  = (state_q == DIV_DONE) && !annul_i;
  assign stall_o  = start_i & ~ready_o & ~annul_i & rst;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_sched.sv
// Directed, table-driven bench for div_sched (latency, results, annul and reset corners).
module tb_div_sched;
  import div_sched_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                start_i;
  logic                signed_i;
  logic [31:0]         dividend_i;
  logic [31:0]         divisor_i;
  logic                annul_i;
  logic                stall_o;
  logic                busy_o;
  logic                ready_o;
  logic [RESULT_W-1:0] result_o;

  int tests = 0;
  int fails = 0;

`ifdef DIV_FAST_ZERO_EN
  localparam int ZLAT = 2;
`else
  localparam int ZLAT = 33;
`endif

  typedef struct {
    logic                sgn;
    logic [31:0]         dvd;
    logic [31:0]         dvs;
    logic [RESULT_W-1:0] exp;
    int                  lat;
  } vec_t;

  vec_t vecs[11];

  div_sched #(.DIV_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .signed_i   (signed_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .annul_i    (annul_i),
    .stall_o    (stall_o),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after the DONE cycle.
  task automatic applyStimulus(input logic sgn, input logic [31:0] dvd, input logic [31:0] dvs,
                               input logic [63:0] exp, input int explat, input string name);
    int lat = 0;
    int bad = 0;
    bit got = 0;
    start_i    = 1'b1;
    signed_i   = sgn;
    dividend_i = dvd;
    divisor_i  = dvs;
    #1;
    if (!stall_o) bad++;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready_o) begin
        got = 1;
        if (stall_o || busy_o) bad++;
      end else if (!stall_o || !busy_o) begin
        bad++;
      end
    end
    start_i = 1'b0;
    checkOutput({name, " latency"}, 64'(lat), 64'(explat));
    checkOutput({name, " result"}, result_o, exp);
    checkOutput({name, " stall/busy"}, 64'(bad), 64'd0);
    @(negedge clk);
    checkOutput({name, " ready drop"}, 64'(ready_o), 64'd0);
  endtask

  initial begin
    int rdy_cnt;
    logic [63:0] prev;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14},               33};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
    vecs[2]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000},         33};
    vecs[3]  = '{1'b0, 32'h0000_1234,  32'h0,          {32'h0000_1234, 32'hFFFF_FFFF}, ZLAT};
    vecs[4]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'h0, 32'hFFFF_FFFF},         33};
    vecs[5]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD},         33};
    vecs[6]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14},        33};
    vecs[7]  = '{1'b0, 32'd5,          32'd10,         {32'd5, 32'd0},                 33};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF8,  32'h0,          {32'hFFFF_FFF8, 32'hFFFF_FFFF}, ZLAT};
    vecs[9]  = '{1'b0, 32'hDEAD_BEEF,  32'h10,         {32'hF, 32'h0DEA_DBEE},         33};
    vecs[10] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h8000_0000, 32'h0},         33};

    rst = 1'b0; start_i = 1'b0; signed_i = 1'b0; dividend_i = '0; divisor_i = '0; annul_i = 1'b0;
    #1 start_i = 1'b1;
    #1;
    checkOutput("reset result", result_o, 64'd0);
    checkOutput("reset flags", 64'({busy_o, ready_o, stall_o}), 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i].sgn, vecs[i].dvd, vecs[i].dvs, vecs[i].exp, vecs[i].lat,
                    $sformatf("vec%0d", i));
    end
    prev = vecs[10].exp;

    // Annul in the middle of ON: nothing retires, previous result stays.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (10) @(negedge clk);
    checkOutput("annul busy before", 64'(busy_o), 64'd1);
    annul_i = 1'b1;
    #1;
    checkOutput("annul gates stall/ready", 64'({stall_o, ready_o}), 64'd0);
    @(negedge clk);
    annul_i = 1'b0;
    start_i = 1'b0;
    checkOutput("annul to idle", 64'({busy_o, ready_o}), 64'd0);
    checkOutput("annul keeps result", result_o, prev);
    applyStimulus(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33, "post-annul 9/3");

    // Reset in the middle of ON: outputs clear at once, no stray strobe.
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd3;
    repeat (20) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("midreset flags", 64'({busy_o, ready_o, stall_o}), 64'd0);
    checkOutput("midreset result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    rdy_cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready_o || busy_o) rdy_cnt++;
    end
    checkOutput("no spurious ready", 64'(rdy_cnt), 64'd0);
    applyStimulus(1'b0, 32'd50, 32'd5, {32'd0, 32'd10}, 33, "post-reset 50/5");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
